// File: rtl/uart_pkg.sv
// Shared UART constants for the serial_r receiver and its downstream buffer.
//   BYTE_W         : width of one received byte
//   START_SAMPLE   : clocks from the start-bit edge to the first sample point
//   BIT_PERIOD     : clocks per bit on the line
//   DEFAULT_DEPTH  : default receive buffer depth (power of two)
package uart_pkg;

    localparam int unsigned BYTE_W        = 8;
    localparam int unsigned START_SAMPLE  = 1950;
    localparam int unsigned BIT_PERIOD    = 5200;
    localparam int unsigned DEFAULT_DEPTH = 16;

endpackage

// File: rtl/uart_rx_buffer_sync_fifo.sv
// sync_fifo: single-clock FIFO with storage, pointers and occupancy count.
//   clk_i      : clock, rising edge
//   rst_i      : synchronous active-high reset (pointers and count only)
//   push_i     : write request; data_i is written when push_ok_o=1
//   data_i     : write data
//   pop_i      : read strobe; caller only asserts it while count_o != 0
//   push_ok_o  : push accepted this cycle (room, or full with a pop alongside)
//   data_o     : head entry, combinational read of storage
//   count_o    : registered occupancy, 0..DEPTH
module sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH = BYTE_W,
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             push_ok_o,
    output logic [WIDTH-1:0] data_o,
    output logic [AW:0]      count_o
);

    localparam logic [AW:0] DepthCnt = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full;

    assign full      = (count_q == DepthCnt);
    // A full FIFO still takes a byte when the head leaves on the same edge.
    assign push_ok_o = push_i & (~full | pop_i);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so pointer wrap is the natural overflow.
        if (push_ok_o) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_i)     rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({push_ok_o, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push_ok_o) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: receive buffer downstream of the serial_r UART receiver.
// Captures completed bytes into a FIFO, re-arms the receiver while there is room,
// presents bytes on a valid/ready interface and flags dropped bytes.
//   m_clock      : system clock, rising edge
//   p_reset      : synchronous active-high reset
//   rx_data      : received byte, valid while rx_complete=1
//   rx_complete  : one-cycle byte-done pulse from the receiver
//   rx_launch    : arm request to the receiver (room available, not in reset)
//   out_data     : head byte, valid while out_valid=1
//   out_valid    : FIFO non-empty
//   out_ready    : consumer takes the head byte when out_valid & out_ready
//   count        : occupancy, 0..DEPTH
//   overrun      : sticky flag, a byte was dropped
//   clr_overrun  : clears overrun (a same-cycle drop wins)
// Optional macro UART_RX_BUFFER_WATERMARK_EN adds:
//   thresh       : occupancy threshold, 0 disables the interrupt
//   level_irq    : registered (next occupancy >= thresh)
module uart_rx_buffer
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              m_clock,
    input  logic              p_reset,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_complete,
    output logic              rx_launch,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [AW:0]       count,
    output logic              overrun,
    input  logic              clr_overrun
`ifdef UART_RX_BUFFER_WATERMARK_EN
    ,
    input  logic [AW:0]       thresh,
    output logic              level_irq
`endif
);

    localparam logic [AW:0] DepthCnt = (AW + 1)'(DEPTH);

    logic push_ok;
    logic pop;
    logic overrun_q, overrun_d;

    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;

    sync_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk_i     (m_clock),
        .rst_i     (p_reset),
        .push_i    (rx_complete),
        .data_i    (rx_data),
        .pop_i     (pop),
        .push_ok_o (push_ok),
        .data_o    (out_data),
        .count_o   (count)
    );

    assign rx_launch = ~p_reset & (count < DepthCnt);

    always_comb begin
        overrun_d = overrun_q;
        if (rx_complete && !push_ok) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge m_clock) begin
        if (p_reset) overrun_q <= 1'b0;
        else         overrun_q <= overrun_d;
    end

    assign overrun = overrun_q;

`ifdef UART_RX_BUFFER_WATERMARK_EN
    logic [AW:0] count_next;
    logic        level_q, level_d;

    always_comb begin
        unique case ({push_ok, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
        level_d = (thresh != '0) && (count_next >= thresh);
    end

    always_ff @(posedge m_clock) begin
        if (p_reset) level_q <= 1'b0;
        else         level_q <= level_d;
    end

    assign level_irq = level_q;
`endif

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed self-checking bench for uart_rx_buffer (DEPTH=16).
module tb_uart_rx_buffer;

    logic       m_clock = 1'b0;
    logic       p_reset;
    logic [7:0] rx_data;
    logic       rx_complete;
    logic       rx_launch;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] count;
    logic       overrun;
    logic       clr_overrun;
`ifdef UART_RX_BUFFER_WATERMARK_EN
    logic [4:0] thresh;
    logic       level_irq;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 m_clock = ~m_clock;

    uart_rx_buffer dut (
        .m_clock     (m_clock),
        .p_reset     (p_reset),
        .rx_data     (rx_data),
        .rx_complete (rx_complete),
        .rx_launch   (rx_launch),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .count       (count),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
`ifdef UART_RX_BUFFER_WATERMARK_EN
        ,
        .thresh      (thresh),
        .level_irq   (level_irq)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    // Inputs change 1 time unit after the edge; checks then see post-edge state.
    task automatic step();
        @(posedge m_clock);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_data     = b;
        rx_complete = 1'b1;
        step();
        rx_complete = 1'b0;
    endtask

    initial begin
        int got_idx;
        int max_cnt;

        p_reset     = 1'b1;
        rx_data     = 8'h00;
        rx_complete = 1'b0;
        out_ready   = 1'b0;
        clr_overrun = 1'b0;
`ifdef UART_RX_BUFFER_WATERMARK_EN
        thresh      = 5'd0;
`endif

        // 1: reset then idle
        step();
        step();
        check_eq("launch_in_reset", rx_launch, 1'b0);
        check_eq("valid_in_reset", out_valid, 1'b0);
        p_reset = 1'b0;
        step();
        check_eq("reset_count", count, 5'd0);
        check_eq("reset_valid", out_valid, 1'b0);
        check_eq("reset_launch", rx_launch, 1'b1);
        check_eq("reset_overrun", overrun, 1'b0);

        // 2: two bytes, then drain
        push_byte(8'h41);
        check_eq("t2_valid_after_push", out_valid, 1'b1);
        push_byte(8'h42);
        check_eq("t2_count2", count, 5'd2);
        check_eq("t2_head", out_data, 8'h41);
        out_ready = 1'b1;
        check_eq("t2_read0", out_data, 8'h41);
        step();
        check_eq("t2_read1", out_data, 8'h42);
        step();
        out_ready = 1'b0;
        check_eq("t2_count0", count, 5'd0);
        check_eq("t2_valid0", out_valid, 1'b0);

        // 3: fill, overflow, clear
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        check_eq("t3_full_count", count, 5'd16);
        check_eq("t3_full_launch", rx_launch, 1'b0);
        check_eq("t3_head", out_data, 8'h00);
        push_byte(8'hAA);
        check_eq("t3_overrun_set", overrun, 1'b1);
        check_eq("t3_count_kept", count, 5'd16);
        check_eq("t3_head_kept", out_data, 8'h00);
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
        check_eq("t3_overrun_clr", overrun, 1'b0);

        // 4: push and pop together on a full FIFO
        rx_data     = 8'h55;
        rx_complete = 1'b1;
        out_ready   = 1'b1;
        step();
        rx_complete = 1'b0;
        check_eq("t4_count_full", count, 5'd16);
        check_eq("t4_overrun", overrun, 1'b0);
        for (int k = 0; k < 16; k++) begin
            check_eq($sformatf("t4_drain%0d", k), out_data,
                     (k < 15) ? 32'(k + 1) : 32'h55);
            step();
        end
        out_ready = 1'b0;
        check_eq("t4_empty", count, 5'd0);

        // 5: streaming through the pointer wrap
        got_idx   = 0;
        max_cnt   = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 23; i++) begin
            rx_complete = (i < 20);
            rx_data     = 8'(8'h80 + i);
            if (out_valid) begin
                check_eq($sformatf("t5_order%0d", got_idx), out_data, 32'(8'h80 + got_idx));
                got_idx++;
            end
            step();
            if (int'(count) > max_cnt) max_cnt = int'(count);
        end
        rx_complete = 1'b0;
        out_ready   = 1'b0;
        check_eq("t5_all_seen", got_idx, 20);
        check_eq("t5_max_count_le2", (max_cnt <= 2), 1'b1);
        check_eq("t5_empty", count, 5'd0);

        // 6: reset mid-stream with a coincident byte
        for (int i = 0; i < 5; i++) push_byte(8'(8'h10 + i));
        check_eq("t6_count5", count, 5'd5);
        p_reset     = 1'b1;
        rx_complete = 1'b1;
        rx_data     = 8'hEE;
        step();
        p_reset     = 1'b0;
        rx_complete = 1'b0;
        check_eq("t6_count_reset", count, 5'd0);
        check_eq("t6_valid_reset", out_valid, 1'b0);
        step();
        check_eq("t6_count_stays0", count, 5'd0);

`ifdef UART_RX_BUFFER_WATERMARK_EN
        check_eq("wm_reset", level_irq, 1'b0);
        thresh = 5'd4;
        for (int i = 0; i < 4; i++) begin
            push_byte(8'(i));
            check_eq($sformatf("wm_push%0d", i + 1), level_irq, (i == 3) ? 1'b1 : 1'b0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_eq("wm_count3", count, 5'd3);
        check_eq("wm_fall", level_irq, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_buffer.md
Name: uart_rx_buffer

Overview:
Receive-side buffer sitting directly downstream of the serial_r UART receiver.
- Captures each byte presented on serial_r's DATA/complete pulse into a small synchronous FIFO.
- Re-arms the receiver through its launch input whenever there is room.
- Offers bytes to the consumer logic over a valid/ready handshake.
- Flags overrun if a byte arrives with no space.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2.
AW, 4, pointer width, log2(DEPTH).

Ports:
m_clock  input  1  system clock; all logic on rising edge.
p_reset  input  1  synchronous, active-high reset.
rx_data  input  8  byte from receiver; valid only while rx_complete=1.
rx_complete  input  1  one-cycle byte-done pulse from receiver.
rx_launch  output  1  arm request to receiver; level, ignored by receiver while it is busy.
out_data  output  8  head-of-FIFO byte; valid while out_valid=1.
out_valid  output  1  FIFO non-empty.
out_ready  input  1  consumer accepts head byte when out_valid&out_ready.
count  output  AW+1  current occupancy, 0..DEPTH.
overrun  output  1  sticky: a byte was dropped.
clr_overrun  input  1  clears overrun.

Behaviour:
- Reset, applied synchronously on the clock edge with p_reset=1:
  - Pointers and count go to 0; overrun goes to 0.
  - out_valid=0 and rx_launch=0 for the reset cycle, as rx_launch is gated by ~p_reset.
  - Storage contents are don't-care.
  - A reset mid-stream discards all buffered bytes. A rx_complete in the reset cycle is ignored.
- push = rx_complete. pop = out_valid & out_ready.
- Accepting a push:
  - Accepted when count<DEPTH, or when count==DEPTH and pop is asserted in the same cycle.
  - On acceptance, rx_data is written at wr_ptr and wr_ptr increments modulo DEPTH.
- A push that is not accepted:
  - The byte is dropped and overrun is set to 1 on the next edge.
  - Pointers are unchanged.
- pop: rd_ptr increments modulo DEPTH.
- count update, evaluated on the same edge:
  - push_ok & ~pop: +1.
  - pop & ~push_ok: -1.
  - Both or neither: unchanged.
- out_data is a combinational read of mem[rd_ptr]. out_valid = (count!=0).
- Latency: a byte pushed at edge N is visible on out_valid/out_data after edge N. There is no same-cycle fall-through.
- Push on empty with out_ready=1: the byte is not popped in the same cycle. It pops one cycle later.
- rx_launch = ~p_reset & (count<DEPTH), combinational from registered count.
  - The receiver consumes at most one byte per arm.
  - count is updated on the edge where the receiver returns to idle.
  - So overrun cannot occur with serial_r attached. It exists for robustness and for the bench.
- overrun priority:
  - Set has priority over clr_overrun in the same cycle.
  - Otherwise clr_overrun=1 clears it next edge.
- Pointer wrap: from DEPTH-1 to 0, with no bubble.

Optional Feature:
Macro UART_RX_BUFFER_WATERMARK_EN.
- Defined:
  - Adds input thresh [AW:0] and output level_irq.
  - level_irq is registered and equals (count_next >= thresh), with thresh==0 treated as never.
  - level_irq is 0 at reset.
- Undefined:
  - The port and its logic are absent.
  - All other behaviour is identical.

Decomposition:
Shared package uart_pkg holds:
- BYTE_W=8.
- Baud divider constants shared with serial_r: start-sample 1950 and bit period 5200 clocks.
- Default DEPTH.

One natural sub-module: sync_fifo.
- Storage array, pointers and count logic, parameterised by width and DEPTH.
- uart_rx_buffer wraps it and adds launch, overrun and watermark logic.

Test Plan:
1. Reset then idle: count=0, out_valid=0, rx_launch=1 one cycle after reset deasserts, overrun=0.
2. Pulse rx_complete with rx_data=0x41, then 0x42, out_ready=0: count=2, out_data=0x41. Raise out_ready for 2 cycles: reads 0x41 then 0x42, count=0.
3. Fill 16 bytes 0x00..0x0F: count=16, rx_launch=0. Push 0xAA: overrun=1, count=16, 0xAA never appears. Assert clr_overrun: overrun=0.
4. Full FIFO with push 0x55 and pop in the same cycle: count stays 16, 0x55 becomes the last byte read, overrun=0.
5. Push 20 bytes while popping continuously to force pointer wrap: output order matches input, count never exceeds 2.
6. Reset asserted with count=5 and rx_complete=1 in the same cycle: count=0, out_valid=0 next cycle. With UART_RX_BUFFER_WATERMARK_EN and thresh=4: level_irq rises on the 4th push and falls after a pop to 3.
